// File: rtl/unified_mem_responder.sv
// Purpose : responder for the core's unified single-ported memory; arbitrates fetch and data onto one word array.
// Latency : one cycle; rvalid and rdata register at the granting edge, so the response arrives in the cycle after the grant.
// Backpressure: at most one grant per cycle and data wins ties; a losing requester holds its request until granted.
//
// Ports:
//   clk, rst                       clock; asynchronous active-low reset
//   i_req/i_addr -> i_gnt          fetch request channel (word fetch, i_addr[1:0] ignored)
//   i_rvalid/i_rdata               registered fetch response
//   d_req/d_we/d_funct3/d_addr/d_wdata -> d_gnt   load/store request channel
//   d_rvalid/d_rdata/d_err         registered load/store response and fault flag
//
// Build option: MISALIGN_TRAP_EN. When defined, misaligned H/HU/W accesses
// fault (no write, zero data, d_err). When undefined, they are aligned down.
module unified_mem_responder #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err
);

  localparam int WIDX_W = ADDR_W - 2;
  localparam int DEPTH  = 1 << WIDX_W;
  localparam int CNT_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RESP_D = 2'b01,
    RESP_I = 2'b10
  } state_t;

  // Storage is deliberately left out of reset: contents survive rst.
  logic [31:0] mem [DEPTH];

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;

  // ---------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------
  logic fetch_prio;
  assign fetch_prio = (starve_cnt == CNT_W'(STARVE_MAX));

  // Grants are suppressed while reset is asserted so nothing can be
  // written or left in flight during reset.
  assign d_gnt = rst & d_req & ~(i_req & fetch_prio);
  assign i_gnt = rst & i_req & ~d_gnt;

  // ---------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------
  logic size_b, size_h, size_w, sext, illegal;

  always_comb begin
    size_b  = 1'b0;
    size_h  = 1'b0;
    size_w  = 1'b0;
    sext    = 1'b0;
    illegal = 1'b0;
    case (d_funct3)
      3'b000:  begin size_b = 1'b1; sext = 1'b1; end
      3'b001:  begin size_h = 1'b1; sext = 1'b1; end
      3'b010:  size_w = 1'b1;
      3'b100:  size_b = 1'b1;
      3'b101:  size_h = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  logic       d_fault;
  logic [1:0] d_off;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (size_h & d_addr[0]) | (size_w & (d_addr[1:0] != 2'b00));
  assign d_fault    = illegal | misaligned;
  assign d_off      = d_addr[1:0];
`else
  // Misaligned accesses are aligned down by clearing the offending offset bits.
  assign d_fault = illegal;
  assign d_off   = size_w ? 2'b00 :
                   size_h ? {d_addr[1], 1'b0} :
                            d_addr[1:0];
`endif

  logic [WIDX_W-1:0] d_widx, i_widx;
  assign d_widx = d_addr[ADDR_W-1:2];
  assign i_widx = i_addr[ADDR_W-1:2];

  // Fetches are always whole words; the byte offset is intentionally dropped.
  logic unused_i_off;
  assign unused_i_off = ^i_addr[1:0];

  logic [31:0] d_word, i_word;
  assign d_word = mem[d_widx];
  assign i_word = mem[i_widx];

  // ---------------------------------------------------------------
  // Load extraction and extension
  // ---------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_res;

  assign ld_byte = d_word[8*d_off +: 8];
  assign ld_half = d_off[1] ? d_word[31:16] : d_word[15:0];

  always_comb begin
    ld_res = d_word;
    if (size_b)      ld_res = {{24{sext & ld_byte[7]}}, ld_byte};
    else if (size_h) ld_res = {{16{sext & ld_half[15]}}, ld_half};
  end

  // ---------------------------------------------------------------
  // Store lane steering
  // ---------------------------------------------------------------
  logic [3:0]  st_be;
  logic [31:0] st_lanes;

  always_comb begin
    st_be    = 4'b1111;
    st_lanes = d_wdata;
    if (size_b) begin
      st_be    = 4'b0001 << d_off;
      st_lanes = {4{d_wdata[7:0]}};
    end else if (size_h) begin
      st_be    = d_off[1] ? 4'b1100 : 4'b0011;
      st_lanes = {2{d_wdata[15:0]}};
    end
  end

  logic store_en;
  assign store_en = d_gnt & d_we & ~d_fault;

  // The write lands at the granting edge, so any access granted in the
  // following cycle (including a deferred same-word fetch) sees it.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[d_widx][8*i +: 8] <= st_lanes[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------
  // Response state machine, starvation counter, response registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      // Any state accepts a new grant, giving back-to-back accesses.
      if (d_gnt)      state <= RESP_D;
      else if (i_gnt) state <= RESP_I;
      else            state <= IDLE;

      if (!i_req || i_gnt)                       starve_cnt <= '0;
      else if (starve_cnt != CNT_W'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;

      if (d_gnt) begin
        // Stores and faulting accesses acknowledge with zero data.
        d_rdata <= (d_we || d_fault) ? 32'h0 : ld_res;
        d_err   <= d_fault;
      end

      if (i_gnt) i_rdata <= i_word;
    end
  end

  assign d_rvalid = (state == RESP_D);
  assign i_rvalid = (state == RESP_I);

endmodule

// File: doc/unified_mem_responder.md
Name: unified_mem_responder

Overview:
Responder end of the unified single-ported memory protocol that the pipelined core uses for instruction fetch and load/store. It accepts fetch and data requests on two independent req/gnt channels and arbitrates them onto one word-organised storage array. It performs RV32 byte, half and word loads and stores selected by funct3, and returns registered responses one cycle after each grant.

Parameters:
ADDR_W, 12, byte-address width; storage holds 2^(ADDR_W-2) 32-bit words.
STARVE_MAX, 3, consecutive denied fetch cycles after which fetch is forced ahead of data.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
i_req  in  1  fetch request
i_addr  in  ADDR_W  fetch byte address (word fetch)
i_gnt  out  1  fetch accepted this cycle (combinational)
i_rvalid  out  1  fetch response valid (registered)
i_rdata  out  32  fetched word
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data, right-aligned
d_gnt  out  1  data accepted this cycle (combinational)
d_rvalid  out  1  data response valid (registered)
d_rdata  out  32  load result, extended per funct3
d_err  out  1  misaligned/illegal-funct3 flag, qualified by d_rvalid

Behaviour:
- Reset (rst low, asynchronous): i_rvalid, d_rvalid, d_err = 0; i_rdata, d_rdata = 0; starve_cnt = 0; arbiter state = IDLE. Storage contents are not cleared. A grant in flight when reset asserts is dropped and no response is issued.
- Grant (combinational): only one grant may be asserted per cycle. Data wins when both channels request. The exception is starve_cnt == STARVE_MAX, in which case fetch wins. The loser must hold its request.
- Starvation counter: increments each cycle where i_req=1 and i_gnt=0, saturating at STARVE_MAX. It clears on i_gnt or i_req=0.
- State machine (registered): IDLE -> RESP_D on d_gnt; IDLE -> RESP_I on i_gnt. RESP_D and RESP_I behave as IDLE for new grants, giving one access per cycle back-to-back. With no grant the machine returns to IDLE.
- Response timing: rvalid pulses exactly in cycle N+1 for a grant in cycle N. rdata is held until the next response. The non-responding channel's rvalid is 0.
- Word index is addr[ADDR_W-1:2]. Loads select the byte lane by addr[1:0] and the half lane by addr[1]. B/H sign-extend; BU/HU zero-extend.
- Stores: at the granting edge, only the addressed lanes are written: SB one byte, SH two bytes, SW four bytes. A store also gets a d_rvalid acknowledge with d_rdata = 0.
- Read-after-write: a read granted in the cycle after a store sees the new data. Fetch and store to the same word in the same cycle: the store is granted first, and the later fetch returns the stored word.
- Illegal funct3 (011, 110, 111): no write; d_rdata = 0; d_err = 1 with the response.
- Misalignment is handled per MISALIGN_TRAP_EN (see Optional Feature).
- Fetch ignores i_addr[1:0]. Address wrap is implicit in ADDR_W truncation.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, is misaligned. A misaligned access writes nothing, returns d_rdata = 0 and sets d_err = 1.
- Undefined: the low address bits that would be misaligned are forced to 0 (access aligned down) and d_err is driven only by illegal funct3.

Test Plan:
- Reset hold: assert rst low mid-grant with d_req=1 -> next cycle d_rvalid=0 and i_rvalid=0. Release reset, read word 0x10 -> previously stored value is still present (storage not cleared).
- Byte/half extend: SW 0x8001_FF80 @0x20, then LB @0x20 -> 0xFFFF_FF80; LBU @0x20 -> 0x0000_0080; LH @0x22 -> 0xFFFF_8001; LHU @0x22 -> 0x0000_8001. Each response arrives one cycle after its grant.
- Partial store: SW 0x1122_3344 @0x40, SB 0xAB @0x41, SH 0xBEEF @0x42, LW @0x40 -> 0xBEEF_AB44. Each store is acknowledged with d_rvalid=1 and d_rdata=0.
- Arbitration/starvation: hold i_req=1 and d_req=1 continuously -> d_gnt for 3 cycles, i_gnt on the 4th, repeating. Exactly one grant per cycle.
- Same-word conflict: in one cycle, SW 0xCAFE_F00D @0x80 and fetch @0x80 -> store granted first, fetch granted next cycle, i_rdata = 0xCAFE_F00D.
- Misalign: LW @0x42. With MISALIGN_TRAP_EN: d_err=1, d_rdata=0, and an SW @0x42 leaves word 0x40 unchanged. Without it: d_err=0, returns word 0x40.
